stream_capture_replay: RTL and testbench



---
 rtl/stream_capture_replay_if.sv | 38 +++
 rtl/stream_capture_replay.sv | 183 ++++++++++++++++++
 tb/tb_stream_capture_replay.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_capture_replay_if.sv
// rtl/stream_capture_replay_if.sv - stb/ack capture and replay stream bundle
//
// Groups the two stb/ack streams of stream_capture_replay.
//   in_data / in_stb / in_ack    : capture stream (upstream -> block)
//   out_data / out_stb / out_ack : replay stream (block -> downstream)
// Modports:
//   slave  : the capture/replay block itself
//   master : the environment driving capture data and accepting replay data
// A word moves on a rising clock edge where stb and ack are both 1.

interface stream_capture_replay_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_stb;
    logic                  in_ack;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_stb;
    logic                  out_ack;

    modport slave (
        input  in_data,
        input  in_stb,
        output in_ack,
        output out_data,
        output out_stb,
        input  out_ack
    );

    modport master (
        output in_data,
        output in_stb,
        input  in_ack,
        input  out_data,
        input  out_stb,
        output out_ack
    );
endinterface

// File: rtl/stream_capture_replay.sv
// rtl/stream_capture_replay.sv - capture NO_OF_VALUES stream words, then replay them in order
//
// Consumes a stb/ack stream into on-chip memory until NO_OF_VALUES words have
// been stored, raises full, then replays the stored words in order as a
// stb/ack master. Terminal DONE state is left only through rst.
//
// Parameters:
//   DATA_WIDTH   : word width in bits
//   DEPTH        : buffer entries, power of two, >= 2
//   NO_OF_VALUES : words captured then replayed, 1 .. DEPTH
//
// Ports:
//   clk    : single clock, rising edge
//   rst    : synchronous, active-high reset
//   bus    : stream_capture_replay_if.slave (capture in_*, replay out_*)
//   full   : NO_OF_VALUES words captured, sticky until rst
//   done   : all words replayed, sticky until rst
//   cycles : cycle count at the final capture transfer
//
// Optional feature macro: STREAM_CAPTURE_CYCLE_COUNT_EN
//   defined   : free-running 32-bit counter; cycles latches its value at the
//               final capture transfer (cycles since rst deasserted)
//   undefined : counter absent, cycles tied to 0

module stream_capture_replay #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int NO_OF_VALUES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    stream_capture_replay_if.slave  bus,
    output logic                    full,
    output logic                    done,
    output logic [31:0]             cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NO_OF_VALUES - 1);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        PRIME   = 2'd1,
        REPLAY  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_stb_q;
    logic                  in_ack_c;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  in_last;
    logic                  out_last;
    logic [AW-1:0]         rd_addr;

    // Capture side is only ready while capturing and out of reset; the
    // reset term keeps in_ack low combinationally during rst.
    assign in_ack_c   = (state == CAPTURE) & ~rst;
    assign bus.in_ack = in_ack_c;

    assign bus.out_data = out_data_q;
    assign bus.out_stb  = out_stb_q;

    assign in_xfer  = bus.in_stb & in_ack_c;
    assign out_xfer = out_stb_q & bus.out_ack;
    assign in_last  = (wr_cnt == LAST_IDX);
    assign out_last = (rd_cnt == LAST_IDX);

    // PRIME always fetches entry 0; REPLAY fetches the entry after the one
    // currently presented so the next word is ready for a back-to-back ack.
    assign rd_addr = (state == PRIME) ? '0 : (rd_cnt[AW-1:0] + AW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            CAPTURE: begin
                if (in_xfer && in_last) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                state_nxt = REPLAY;
            end
            REPLAY: begin
                if (out_xfer && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = CAPTURE;
            end
        endcase
    end

    // Buffer write port. Contents survive rst; they are only replayed after
    // a full re-capture because the FSM restarts in CAPTURE.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem[wr_cnt[AW-1:0]] <= bus.in_data;
        end
    end

    // Counters, replay register and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            out_data_q <= '0;
            out_stb_q  <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (in_xfer) begin
                wr_cnt <= wr_cnt + CW'(1);
                if (in_last) begin
                    full <= 1'b1;
                end
            end

            if (state == PRIME) begin
                out_data_q <= mem[rd_addr];
                out_stb_q  <= 1'b1;
                rd_cnt     <= '0;
            end

            if (state == REPLAY && out_xfer) begin
                if (out_last) begin
                    out_stb_q <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    out_data_q <= mem[rd_addr];
                    rd_cnt     <= rd_cnt + CW'(1);
                end
            end
        end
    end

`ifdef STREAM_CAPTURE_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] cycles_q;

    // cyc_cnt is 0 on the first edge after rst drops, so the value latched
    // at the final capture is the number of cycles since release.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt  <= '0;
            cycles_q <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (in_xfer && in_last) begin
                cycles_q <= cyc_cnt;
            end
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_stream_capture_replay.sv
// tb/tb_stream_capture_replay.sv - randomized self-checking bench for stream_capture_replay

module tb_stream_capture_replay;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int NV    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        full0, done0, full1, done1;
    logic [31:0] cycles0, cycles1;

    always #5 clk = ~clk;

    stream_capture_replay_if #(.DATA_WIDTH(DW)) bus0 ();
    stream_capture_replay_if #(.DATA_WIDTH(DW)) bus1 ();

    stream_capture_replay #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NO_OF_VALUES(NV)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus0.slave),
        .full   (full0),
        .done   (done0),
        .cycles (cycles0)
    );

    stream_capture_replay #(.DATA_WIDTH(DW), .DEPTH(2), .NO_OF_VALUES(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus1.slave),
        .full   (full1),
        .done   (done1),
        .cycles (cycles1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the list of accepted words, how many were replayed,
    // and how many edges have passed since the buffer filled.
    logic [31:0] cap_q[$];
    int          n_out;
    int          age;
    int          cyc;
    logic [31:0] exp_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int n_cap();
        return cap_q.size();
    endfunction

    // One clock cycle: check outputs at negedge against the model, predict
    // the transfers of the coming edge, then advance the model past it.
    task automatic step();
        logic        e_in_ack, e_out_stb, in_x, out_x;
        logic [31:0] in_word;
        @(negedge clk);
        e_in_ack  = !rst && (n_cap() < NV);
        e_out_stb = (n_cap() == NV) && (age >= 1) && (n_out < NV);
        check("in_ack", bus0.in_ack, e_in_ack);
        check("out_stb", bus0.out_stb, e_out_stb);
        check("full", full0, n_cap() == NV);
        check("done", done0, n_out == NV);
`ifdef STREAM_CAPTURE_CYCLE_COUNT_EN
        check("cycles", cycles0, exp_cycles);
`else
        check("cycles", cycles0, 0);
`endif
        if (e_out_stb) begin
            check("out_data", bus0.out_data, cap_q[n_out]);
        end
        in_x    = e_in_ack && bus0.in_stb;
        out_x   = e_out_stb && bus0.out_ack;
        in_word = bus0.in_data;
        @(posedge clk);
        if (rst) begin
            cap_q.delete();
            n_out      = 0;
            age        = 0;
            cyc        = 0;
            exp_cycles = 0;
        end else begin
            if (n_cap() == NV) age++;
            if (in_x) begin
                cap_q.push_back(in_word);
                if (n_cap() == NV) begin
                    age        = 0;
                    exp_cycles = cyc;
                end
            end
            if (out_x) n_out++;
            cyc++;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst          = 1'b1;
        bus0.in_stb  = 1'b1;
        bus0.out_ack = 1'b1;
        repeat (n) step();
        check("rst_out_data", bus0.out_data, 0);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        cap_q.delete();
        n_out = 0; age = 0; cyc = 0; exp_cycles = 0;
        bus0.in_data = '0; bus0.in_stb = 1'b0; bus0.out_ack = 1'b0;
        bus1.in_data = '0; bus1.in_stb = 1'b0; bus1.out_ack = 1'b0;
        @(posedge clk); #1;

        // Reset held 3 cycles with in_stb and out_ack high
        do_reset(3);

        // Streaming 0xA0..0xA3, then 0xFF held on the input after full
        for (int i = 0; i < 12; i++) begin
            bus0.in_stb  = 1'b1;
            bus0.in_data = (n_cap() < NV) ? 32'hA0 + n_cap() : 32'hFF;
            bus0.out_ack = 1'b1;
            step();
        end
        check("stream_done", done0, 1);
        check("stream_last_stb", bus0.out_stb, 0);

        // Backpressure: out_ack 1,0,0,1 repeating
        do_reset(1);
        for (int i = 0; i < 24; i++) begin
            bus0.in_stb  = 1'b1;
            bus0.in_data = $urandom;
            bus0.out_ack = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        check("bp_done", done0, 1);
        check("bp_count", n_out, NV);

        // Gapped input: two idle cycles between words
        do_reset(1);
        for (int i = 0; i < 14; i++) begin
            bus0.in_stb  = (i % 3 == 0);
            bus0.in_data = $urandom;
            bus0.out_ack = 1'b1;
            step();
        end
`ifdef STREAM_CAPTURE_CYCLE_COUNT_EN
        check("gap_cycles", cycles0, 9);
`else
        check("gap_cycles", cycles0, 0);
`endif

        // Reset after two replay transfers, then recapture 0xB0..0xB3
        do_reset(1);
        guard = 0;
        while (n_out < 2 && guard < 30) begin
            bus0.in_stb  = 1'b1;
            bus0.in_data = 32'hC0 + n_cap();
            bus0.out_ack = 1'b1;
            step();
            guard++;
        end
        check("midrep_reached", n_out, 2);
        do_reset(1);
        check("midrep_full", full0, 0);
        check("midrep_stb", bus0.out_stb, 0);
        for (int i = 0; i < 12; i++) begin
            bus0.in_stb  = 1'b1;
            bus0.in_data = (n_cap() < NV) ? 32'hB0 + n_cap() : 32'hFF;
            bus0.out_ack = 1'b1;
            step();
        end
        check("midrep_done", done0, 1);

        // Randomized traffic with occasional mid-run resets
        for (int r = 0; r < 4; r++) begin
            do_reset(1 + $urandom_range(0, 2));
            for (int i = 0; i < 50; i++) begin
                rst          = ($urandom_range(0, 79) == 0);
                bus0.in_stb  = ($urandom_range(0, 3) != 0);
                bus0.in_data = $urandom;
                bus0.out_ack = ($urandom_range(0, 2) != 0);
                step();
            end
            rst = 1'b0;
        end

        // NO_OF_VALUES = 1 instance: PRIME -> REPLAY -> DONE still applies
        rst = 1'b1;
        bus0.in_stb = 1'b0; bus0.out_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus1.in_stb  = 1'b1;
        bus1.in_data = 32'h5A;
        @(negedge clk);
        check("n1_in_ack", bus1.in_ack, 1);
        @(posedge clk); #1;
        bus1.in_stb = 1'b0;
        @(negedge clk);
        check("n1_full", full1, 1);
        check("n1_in_ack_off", bus1.in_ack, 0);
        check("n1_prime_stb", bus1.out_stb, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("n1_out_stb", bus1.out_stb, 1);
        check("n1_out_data", bus1.out_data, 32'h5A);
        bus1.out_ack = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("n1_stb_off", bus1.out_stb, 0);
        check("n1_done", done1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
